// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch/jump squash.
// Optional hazard statistics counters are enabled with `define ID_EX_HAZARD_STATS_EN.
module id_ex_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [RA_W-1:0]    id_rs1,
  input  logic [RA_W-1:0]    id_rs2,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic               id_branch,
  input  logic               id_jump,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               ex_flush,
  input  logic               hold,
  output logic               stall_if_id,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [RA_W-1:0]    ex_rs1,
  output logic [RA_W-1:0]    ex_rs2,
  output logic [RA_W-1:0]    ex_rd,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic [ALUOP_W-1:0] ex_alu_op
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [RA_W-1:0]    rs1;
    logic [RA_W-1:0]    rs2;
    logic [RA_W-1:0]    rd;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic               branch;
    logic               jump;
    logic [ALUOP_W-1:0] alu_op;
  } ex_t;

  ex_t ex_q, ex_d, id_pkt;
  logic rs1_hit, rs2_hit, lu;

  always_comb begin
    id_pkt            = '0;
    id_pkt.valid      = id_valid;
    id_pkt.pc         = id_pc;
    id_pkt.rs1        = id_rs1;
    id_pkt.rs2        = id_rs2;
    id_pkt.rd         = id_rd;
    id_pkt.rs1_data   = id_rs1_data;
    id_pkt.rs2_data   = id_rs2_data;
    id_pkt.imm        = id_imm;
    id_pkt.reg_write  = id_reg_write;
    id_pkt.mem_read   = id_mem_read;
    id_pkt.mem_write  = id_mem_write;
    id_pkt.mem_to_reg = id_mem_to_reg;
    id_pkt.alu_src    = id_alu_src;
    id_pkt.branch     = id_branch;
    id_pkt.jump       = id_jump;
    id_pkt.alu_op     = id_alu_op;
  end

  // A load writing x0 never creates a dependency.
  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_q.rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_q.rd);
  assign lu      = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                   (rs1_hit || rs2_hit);

  // IF/ID is cleared by the redirect on a flush, so no freeze is needed then.
  assign stall_if_id = !ex_flush && (hold || lu);

  // A bubble is the all-zero word: invalid, no control, rd/rs1/rs2 = x0.
  always_comb begin
    ex_d = ex_q;
    if (ex_flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (lu || !id_valid) begin
      ex_d = '0;
    end else begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign ex_alu_op     = ex_q.alu_op;

`ifdef ID_EX_HAZARD_STATS_EN
  logic [31:0] bubble_cnt_q, flush_cnt_q;
  logic        lu_bubble;

  // Counts only bubbles caused by load-use, not idle decode slots.
  assign lu_bubble = !ex_flush && !hold && lu;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (lu_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
      if (ex_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios followed by random traffic,
// checked against a rule-level reference model of the EX-stage slot.
module tb_id_ex_stage;
  localparam int XLEN    = 32;
  localparam int RA_W    = 5;
  localparam int ALUOP_W = 4;

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [RA_W-1:0]    rs1;
    logic [RA_W-1:0]    rs2;
    logic [RA_W-1:0]    rd;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic               branch;
    logic               jump;
    logic [ALUOP_W-1:0] alu_op;
  } st_t;

  typedef struct packed {
    logic chk_stall;
    logic stall;
    st_t  ex;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  st_t  id;
  logic use1, use2, flush, hold;
  logic stall;
  st_t  ex_obs;
  st_t  mdl;
  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  logic               o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic               o_alu_src, o_branch, o_jump;
  logic [XLEN-1:0]    o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [RA_W-1:0]    o_rs1, o_rs2, o_rd;
  logic [ALUOP_W-1:0] o_alu_op;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id.valid), .id_pc(id.pc), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_use_rs1(use1), .id_use_rs2(use2),
    .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data), .id_imm(id.imm),
    .id_reg_write(id.reg_write), .id_mem_read(id.mem_read), .id_mem_write(id.mem_write),
    .id_mem_to_reg(id.mem_to_reg), .id_alu_src(id.alu_src), .id_branch(id.branch),
    .id_jump(id.jump), .id_alu_op(id.alu_op),
    .ex_flush(flush), .hold(hold), .stall_if_id(stall),
    .ex_valid(o_valid), .ex_pc(o_pc), .ex_rs1(o_rs1), .ex_rs2(o_rs2), .ex_rd(o_rd),
    .ex_rs1_data(o_rs1_data), .ex_rs2_data(o_rs2_data), .ex_imm(o_imm),
    .ex_reg_write(o_reg_write), .ex_mem_read(o_mem_read), .ex_mem_write(o_mem_write),
    .ex_mem_to_reg(o_mem_to_reg), .ex_alu_src(o_alu_src), .ex_branch(o_branch),
    .ex_jump(o_jump), .ex_alu_op(o_alu_op)
  );

  assign ex_obs = {o_valid, o_pc, o_rs1, o_rs2, o_rd, o_rs1_data, o_rs2_data, o_imm,
                   o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_branch,
                   o_jump, o_alu_op};

  function automatic st_t rand_id();
    st_t s;
    s.valid      = ($urandom_range(0, 99) < 85);
    s.pc         = $urandom();
    s.rs1        = RA_W'($urandom_range(0, 7));
    s.rs2        = RA_W'($urandom_range(0, 7));
    s.rd         = RA_W'($urandom_range(0, 7));
    s.rs1_data   = $urandom();
    s.rs2_data   = $urandom();
    s.imm        = $urandom();
    s.reg_write  = 1'($urandom_range(0, 1));
    s.mem_read   = 1'($urandom_range(0, 1));
    s.mem_write  = 1'($urandom_range(0, 1));
    s.mem_to_reg = 1'($urandom_range(0, 1));
    s.alu_src    = 1'($urandom_range(0, 1));
    s.branch     = 1'($urandom_range(0, 1));
    s.jump       = 1'($urandom_range(0, 1));
    s.alu_op     = ALUOP_W'($urandom_range(0, 15));
    return s;
  endfunction

  // Reference: the instruction in EX is a load whose destination the decoded one reads.
  task automatic step(input logic r);
    exp_t e;
    logic dep;
    dep = mdl.valid && mdl.mem_read && (mdl.rd != 0) && id.valid &&
          ((use1 && (id.rs1 == mdl.rd)) || (use2 && (id.rs2 == mdl.rd)));
    rst         = r;
    e.chk_stall = !r;
    e.stall     = !flush && (hold || dep);
    if (r || flush)           e.ex = '0;
    else if (hold)            e.ex = mdl;
    else if (dep || !id.valid) e.ex = '0;
    else                      e.ex = id;
    mdl = e.ex;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    id = '0; use1 = 1'b0; use2 = 1'b0; flush = 1'b0; hold = 1'b0;
  endtask

  task automatic load_x(input logic [RA_W-1:0] rd);
    clr(); id.valid = 1'b1; id.mem_read = 1'b1; id.mem_to_reg = 1'b1; id.reg_write = 1'b1;
    id.rd = rd; id.pc = 32'h200; step(1'b0);
  endtask

  // Monitor: stall checked mid-cycle, registered state checked just after the edge.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        it = q[0];
        if (it.chk_stall) begin
          n_cmp++;
          if (stall !== it.stall) begin
            n_fail++;
            $display("FAIL stall_if_id t=%0t got=%b want=%b", $time, stall, it.stall);
          end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (ex_obs !== it.ex) begin
          n_fail++;
          $display("FAIL ex_state t=%0t got=%h want=%h", $time, ex_obs, it.ex);
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin
    mdl = '0;
    clr();
    rst = 1'b1;
    @(posedge clk);
    #2;
    repeat (2) begin
      id = rand_id(); use1 = 1'($urandom_range(0, 1)); use2 = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1)); hold = 1'($urandom_range(0, 1));
      step(1'b1);
    end
    clr(); id = rand_id(); step(1'b0);

    // pass-through
    clr(); id.valid = 1'b1; id.pc = 32'h100; id.rd = 5'd3; id.rs1_data = 32'hDEADBEEF;
    step(1'b0);

    // load-use: lw x5 then add reading x5 through rs2; IF/ID holds the add
    load_x(5'd5);
    clr(); id.valid = 1'b1; id.rs1 = 5'd2; id.rs2 = 5'd5; id.rd = 5'd6; id.reg_write = 1'b1;
    use1 = 1'b1; use2 = 1'b1;
    step(1'b0);
    step(1'b0);

    // no false hazard: load to x0, and unused rs1 matching the load
    load_x(5'd0);
    clr(); id.valid = 1'b1; id.rs1 = 5'd0; use1 = 1'b1; id.rd = 5'd7; step(1'b0);
    load_x(5'd5);
    clr(); id.valid = 1'b1; id.rs1 = 5'd5; use1 = 1'b0; id.rd = 5'd7; step(1'b0);

    // flush wins over a load-use hazard
    load_x(5'd5);
    clr(); id.valid = 1'b1; id.rs1 = 5'd5; use1 = 1'b1; flush = 1'b1; step(1'b0);

    // hold with a pending hazard, then release: exactly one bubble follows
    load_x(5'd4);
    repeat (3) begin
      clr(); id = rand_id(); id.valid = 1'b1; id.rs1 = 5'd4; use1 = 1'b1; hold = 1'b1;
      step(1'b0);
    end
    hold = 1'b0; step(1'b0); step(1'b0);

    // hold without a hazard, then release loads the current decode slot
    repeat (3) begin
      clr(); id = rand_id(); id.mem_read = 1'b0; hold = 1'b1; step(1'b0);
    end
    clr(); id = rand_id(); id.valid = 1'b1; step(1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      id    = rand_id();
      use1  = 1'($urandom_range(0, 1));
      use2  = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      step($urandom_range(0, 49) == 0);
    end

    clr(); rst = 1'b0;
    repeat (5) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core.
- Sits between decode and EX, directly upstream of the forwarding unit: supplies ex_rs1/ex_rs2 for the forwarding compares and holds the EX-stage operands and control.
- Inserts one bubble on a load-use hazard and squashes its contents on a branch/jump flush.

Parameters:
- XLEN, 32, datapath width (PC, register data, immediate)
- RA_W, 5, register address width
- ALUOP_W, 4, ALU op-code width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  PC of decoded instruction
- id_rs1, id_rs2, id_rd  in  RA_W each  register addresses
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  XLEN each  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump  in  1 each  control bits
- id_alu_op  in  ALUOP_W  ALU operation
- ex_flush  in  1  branch/jump redirect resolved in EX
- hold  in  1  global freeze (memory wait)
- stall_if_id  out  1  freeze PC and IF/ID this cycle
- ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_jump, ex_alu_op  out  widths as matching id_*  registered EX-stage state

Behaviour:
- All ex_* outputs are registers updated on the rising edge of clk.
- Reset: every ex_* output is 0 (bubble = NOP with all control 0, ex_rd = 0).
- Bubble write: ex_valid, all control bits, ex_alu_op, ex_rd, ex_rs1, ex_rs2 all 0; the data/pc/imm fields are don't-care and are driven 0.
- Load-use detect (combinational): lu = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Next-state priority, highest first:
  1. rst: all 0.
  2. ex_flush: bubble.
  3. hold: keep all ex_* unchanged.
  4. lu: bubble.
  5. Otherwise: load all id_* into ex_*. If id_valid = 0, load a bubble instead.
- stall_if_id = ~ex_flush & (hold | lu). It is 0 on flush because IF/ID is flushed by the redirect logic.
- Latency: 1 cycle from an id_* input to the matching ex_* output.
- A load-use stall lasts exactly 1 cycle. The next cycle the load has left EX, lu drops, and the dependent instruction enters EX. The forwarding unit then covers it from MEM/WB.
- hold with lu both asserted: the register freezes, stall_if_id = 1, and lu is re-evaluated once hold drops (no lost or duplicated bubble).
- Reset asserted mid-stall: all 0 next cycle and stall_if_id = 0 after reset. stall_if_id is combinational, so while rst is asserted it may still evaluate high.
- ex_rd = 0 instructions never trigger lu (x0 writes are discarded).

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- Defined: adds two output ports, bubble_cnt and flush_cnt (32 bits each). Each is a saturating counter, cleared by rst.
  - bubble_cnt increments on each cycle a load-use bubble is written (priority case 4).
  - flush_cnt increments on each cycle ex_flush = 1.
  - Both hold at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Test Plan:
- Reset: rst = 1 for 2 cycles, inputs random -> all ex_* = 0, and stall_if_id = 0 once rst drops.
- Pass-through: id_valid = 1, id_pc = 0x100, id_rd = 3, id_rs1_data = 0xDEADBEEF, no hazard -> next cycle ex_pc = 0x100, ex_rd = 3, ex_rs1_data = 0xDEADBEEF, ex_valid = 1.
- Load-use:
  - Stimulus: lw x5 in EX (ex_mem_read = 1, ex_rd = 5); id add with id_rs2 = 5, id_use_rs2 = 1.
  - Response: stall_if_id = 1 for one cycle; next ex_valid = 0; the cycle after, the add appears with ex_rs2 = 5.
- No false hazard: lw x0 in EX with id_rs1 = 0, or lw x5 with id_use_rs1 = 0 and id_rs1 = 5 -> stall_if_id = 0 and no bubble.
- Flush vs hazard: ex_flush = 1 together with a load-use condition -> bubble written, stall_if_id = 0.
- Hold: hold = 1 for 3 cycles with changing id_* -> ex_* constant and stall_if_id = 1. After release, the id_* present at that point loads, or a bubble is written if lu = 1.
